// File: rtl/axi4_pkg.sv
// axi4_pkg: shared AXI4 response/burst codes, burst-master state encoding and AxSIZE helper
package axi4_pkg;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    typedef enum logic [2:0] {S_IDLE, S_CHK, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;
    function automatic logic [2:0] axsize(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction
endpackage

// File: rtl/axi4_boundary_chk.sv
// axi4_boundary_chk: flags a burst whose start is not beat-aligned or that runs past its 4KB page
//   addr_lo in  12  low 12 bits of the start byte address
//   len     in  8   beats-1
//   err     out 1   1 = misaligned or crosses a 4KB boundary
module axi4_boundary_chk #(
    parameter int DATA_W = 32
) (
    input  logic [11:0] addr_lo,
    input  logic [7:0]  len,
    output logic        err
);
    localparam int BYTES = DATA_W / 8;
    localparam int LSB   = $clog2(BYTES);
    // 16 bits hold 4095 + 256*64 without overflow; ending exactly on 4096 is legal
    logic [15:0] end_off;
    assign end_off = 16'(addr_lo) + (16'(len) + 16'd1) * 16'(BYTES);
    assign err     = (addr_lo[LSB-1:0] != '0) || (end_off > 16'd4096);
endmodule

// File: rtl/axi4_burst_master.sv
// axi4_burst_master: single-outstanding AXI4 INCR burst master with status reporting
//   cmd_*      command in (dir/addr/len), cmd_ready high only in IDLE
//   wr_*       write beat stream, passed straight onto W (no buffering)
//   rd_*       read beat stream from R; rd_last from the local beat counter
//   done_*     one-cycle completion pulse with first non-OKAY resp and check/RLAST error flag
//   M_AXI_*    AXI4 AW/W/B/AR/R channels (no ID/CACHE/PROT)
module axi4_burst_master
    import axi4_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [7:0]        cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              done_valid,
    output logic [1:0]        done_resp,
    output logic              done_err,
    output logic [ADDR_W-1:0] M_AXI_AWADDR,
    output logic [7:0]        M_AXI_AWLEN,
    output logic [2:0]        M_AXI_AWSIZE,
    output logic [1:0]        M_AXI_AWBURST,
    output logic              M_AXI_AWVALID,
    input  logic              M_AXI_AWREADY,
    output logic [DATA_W-1:0] M_AXI_WDATA,
    output logic [DATA_W/8-1:0] M_AXI_WSTRB,
    output logic              M_AXI_WLAST,
    output logic              M_AXI_WVALID,
    input  logic              M_AXI_WREADY,
    input  logic [1:0]        M_AXI_BRESP,
    input  logic              M_AXI_BVALID,
    output logic              M_AXI_BREADY,
    output logic [ADDR_W-1:0] M_AXI_ARADDR,
    output logic [7:0]        M_AXI_ARLEN,
    output logic [2:0]        M_AXI_ARSIZE,
    output logic [1:0]        M_AXI_ARBURST,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,
    input  logic [DATA_W-1:0] M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              M_AXI_RLAST,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY
);
    localparam logic [2:0] SIZE = axsize(DATA_W);

    state_t            state, state_nxt;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        len_q;
    logic [7:0]        beat;
    logic [1:0]        resp_q;
    logic              err_q;
    logic              chk_err;
    logic              last_beat;
    logic              w_hs;
    logic              r_hs;

    axi4_boundary_chk #(.DATA_W(DATA_W)) u_chk (
        .addr_lo (addr_q[11:0]),
        .len     (len_q),
        .err     (chk_err)
    );

    assign last_beat = (beat == len_q);
    assign w_hs      = M_AXI_WVALID && M_AXI_WREADY;
    assign r_hs      = M_AXI_RVALID && M_AXI_RREADY;

    // cmd_ready is masked by rst so every handshake output reads 0 while reset is held
    assign cmd_ready     = (state == S_IDLE) && !rst;
    assign M_AXI_AWADDR  = addr_q;
    assign M_AXI_AWLEN   = len_q;
    assign M_AXI_AWSIZE  = SIZE;
    assign M_AXI_AWBURST = BURST_INCR;
    assign M_AXI_AWVALID = (state == S_AW);
    assign M_AXI_WDATA   = wr_data;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = (state == S_W) && last_beat;
    assign M_AXI_WVALID  = (state == S_W) && wr_valid;
    assign wr_ready      = (state == S_W) && M_AXI_WREADY;
    assign M_AXI_BREADY  = (state == S_B);
    assign M_AXI_ARADDR  = addr_q;
    assign M_AXI_ARLEN   = len_q;
    assign M_AXI_ARSIZE  = SIZE;
    assign M_AXI_ARBURST = BURST_INCR;
    assign M_AXI_ARVALID = (state == S_AR);
    assign M_AXI_RREADY  = (state == S_R) && rd_ready;
    assign rd_valid      = (state == S_R) && M_AXI_RVALID;
    assign rd_data       = (state == S_R) ? M_AXI_RDATA : '0;
    assign rd_last       = (state == S_R) && last_beat;
    assign done_valid    = (state == S_DONE);
    assign done_resp     = (state == S_DONE) ? resp_q : RESP_OKAY;
    assign done_err      = (state == S_DONE) && err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = cmd_valid ? S_CHK : S_IDLE;
            S_CHK:   state_nxt = chk_err ? S_DONE : (write_q ? S_AW : S_AR);
            S_AW:    state_nxt = M_AXI_AWREADY ? S_W : S_AW;
            S_W:     state_nxt = (w_hs && last_beat) ? S_B : S_W;
            S_B:     state_nxt = M_AXI_BVALID ? S_DONE : S_B;
            S_AR:    state_nxt = M_AXI_ARREADY ? S_R : S_AR;
            S_R:     state_nxt = (r_hs && last_beat) ? S_DONE : S_R;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            beat    <= '0;
            resp_q  <= RESP_OKAY;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (cmd_valid) begin
                    write_q <= cmd_write;
                    addr_q  <= cmd_addr;
                    len_q   <= cmd_len;
                    beat    <= '0;
                    resp_q  <= RESP_OKAY;
                    err_q   <= 1'b0;
                end
                S_CHK: if (chk_err) begin
                    resp_q <= RESP_SLVERR;
                    err_q  <= 1'b1;
                end
                S_W: if (w_hs) beat <= beat + 8'd1;
                S_B: if (M_AXI_BVALID) resp_q <= M_AXI_BRESP;
                S_R: if (r_hs) begin
                    beat <= beat + 8'd1;
                    // keep the first error response; OKAY beats leave it untouched
                    if (resp_q == RESP_OKAY) resp_q <= M_AXI_RRESP;
                    // slave RLAST must agree with our own count; mismatch is sticky
                    if (M_AXI_RLAST != last_beat) err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axi4_burst_master.sv
// tb_axi4_burst_master: scoreboard bench with a reactive AXI slave for the burst master
module tb_axi4_burst_master;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wr_valid, wr_ready;
    logic [31:0] wr_data;
    logic        rd_valid, rd_ready, rd_last;
    logic [31:0] rd_data;
    logic        done_valid, done_err;
    logic [1:0]  done_resp;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;

    axi4_burst_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done_valid(done_valid), .done_resp(done_resp), .done_err(done_err),
        .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
        .M_AXI_AWBURST(awburst), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
        .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
        .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
        .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
        .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
        .M_AXI_ARBURST(arburst), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
        .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
        .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
    );

    logic         cmd_valid2, cmd_ready2, wr_valid2, wr_ready2, rd_valid2, rd_last2;
    logic         done_valid2, done_err2;
    logic [1:0]   done_resp2;
    logic [31:0]  cmd_addr2, awaddr2, araddr2;
    logic [127:0] wr_data2, rd_data2, wdata2;
    logic [7:0]   awlen2, arlen2;
    logic [2:0]   awsize2, arsize2;
    logic [1:0]   awburst2, arburst2;
    logic [15:0]  wstrb2;
    logic         awvalid2, wlast2, wvalid2, bready2, arvalid2, rready2;

    axi4_burst_master #(.ADDR_W(32), .DATA_W(128)) dut2 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_write(1'b1),
        .cmd_addr(cmd_addr2), .cmd_len(8'd0),
        .wr_valid(wr_valid2), .wr_ready(wr_ready2), .wr_data(wr_data2),
        .rd_valid(rd_valid2), .rd_ready(1'b0), .rd_data(rd_data2), .rd_last(rd_last2),
        .done_valid(done_valid2), .done_resp(done_resp2), .done_err(done_err2),
        .M_AXI_AWADDR(awaddr2), .M_AXI_AWLEN(awlen2), .M_AXI_AWSIZE(awsize2),
        .M_AXI_AWBURST(awburst2), .M_AXI_AWVALID(awvalid2), .M_AXI_AWREADY(1'b1),
        .M_AXI_WDATA(wdata2), .M_AXI_WSTRB(wstrb2), .M_AXI_WLAST(wlast2),
        .M_AXI_WVALID(wvalid2), .M_AXI_WREADY(1'b1),
        .M_AXI_BRESP(2'b00), .M_AXI_BVALID(1'b1), .M_AXI_BREADY(bready2),
        .M_AXI_ARADDR(araddr2), .M_AXI_ARLEN(arlen2), .M_AXI_ARSIZE(arsize2),
        .M_AXI_ARBURST(arburst2), .M_AXI_ARVALID(arvalid2), .M_AXI_ARREADY(1'b0),
        .M_AXI_RDATA(128'd0), .M_AXI_RRESP(2'b00), .M_AXI_RLAST(1'b0),
        .M_AXI_RVALID(1'b0), .M_AXI_RREADY(rready2)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // scoreboards: {dir,addr,len}, {wdata,wlast}, {rdata,rd_last}, {resp,err}
    logic [40:0] aq[$];
    logic [32:0] wq[$];
    logic [32:0] rq[$];
    logic [2:0]  dq[$];

    // handshakes seen at the falling edge complete on the following rising edge
    logic hs_cmd, hs_w, hs_b, hs_ar, hs_r, hs_done, w_last_s, aw_prev, ar_prev;
    logic [7:0] ar_len_s;
    int lat = 0;

    // slave configuration
    logic [1:0] cfg_bresp = 2'b00, cfg_rresp1 = 2'b00, cfg_rresp2 = 2'b00;
    bit cfg_w_toggle = 0, cfg_rd_toggle = 0;
    int cfg_bad_last = -1;
    bit r_act = 0;
    int r_beat = 0, r_len = 0;

    always @(negedge clk) begin
        if (rst) begin
            hs_cmd = 0; hs_w = 0; hs_b = 0; hs_ar = 0; hs_r = 0; hs_done = 0;
            aw_prev = 0; ar_prev = 0;
        end else begin
            hs_cmd   = cmd_valid && cmd_ready;
            hs_w     = wvalid && wready;
            w_last_s = wlast;
            hs_b     = bvalid && bready;
            hs_ar    = arvalid && arready;
            ar_len_s = arlen;
            hs_r     = rvalid && rready;
            hs_done  = done_valid;
            lat      = hs_cmd ? 0 : lat + 1;
            if (awvalid && !aw_prev) begin
                check("aw_latency", lat, 2);
                check("aw_size_burst", {awsize, awburst}, {3'd2, 2'b01});
                if (aq.size() == 0) check("aw_spurious", 1, 0);
                else check("aw_addr_len", {1'b1, awaddr, awlen}, aq.pop_front());
            end
            if (arvalid && !ar_prev) begin
                check("ar_latency", lat, 2);
                check("ar_size_burst", {arsize, arburst}, {3'd2, 2'b01});
                if (aq.size() == 0) check("ar_spurious", 1, 0);
                else check("ar_addr_len", {1'b0, araddr, arlen}, aq.pop_front());
            end
            aw_prev = awvalid;
            ar_prev = arvalid;
            if (hs_w) begin
                if (wq.size() == 0) check("w_spurious", 1, 0);
                else check("w_beat", {wdata, wlast}, wq.pop_front());
            end
            if (rd_valid && rd_ready) begin
                if (rq.size() == 0) check("rd_spurious", 1, 0);
                else check("rd_beat", {rd_data, rd_last}, rq.pop_front());
            end
            if (r_act) check("rready_follow", rready, rd_ready);
            if (done_valid) begin
                if (dq.size() == 0) check("done_spurious", 1, 0);
                else check("done", {done_resp, done_err}, dq.pop_front());
            end
        end
    end

    task automatic drive_r();
        rvalid = 1'b1;
        rdata  = $urandom;
        rresp  = (r_beat == 1) ? cfg_rresp1 : (r_beat == 2) ? cfg_rresp2 : 2'b00;
        rlast  = (cfg_bad_last >= 0) ? (r_beat == cfg_bad_last) : (r_beat == r_len);
        rq.push_back({rdata, r_beat == r_len});
    endtask

    always @(posedge clk) begin
        #1;
        if (rst) begin
            bvalid = 0; rvalid = 0; r_act = 0;
        end else begin
            if (hs_b) bvalid = 0;
            if (hs_w && w_last_s) begin
                bvalid = 1;
                bresp  = cfg_bresp;
            end
            if (hs_ar) begin
                r_act = 1; r_beat = 0; r_len = int'(ar_len_s);
                drive_r();
            end else if (hs_r) begin
                r_beat++;
                if (r_beat > r_len) begin
                    r_act = 0; rvalid = 0; rlast = 0;
                end else drive_r();
            end
            wready   = cfg_w_toggle ? !wready : 1'b1;
            awready  = cfg_w_toggle ? !awready : 1'b1;
            rd_ready = cfg_rd_toggle ? !rd_ready : 1'b1;
        end
    end

    task automatic do_cmd(input bit wr, input logic [31:0] a, input logic [7:0] l,
                          input logic [1:0] er, input bit ee, input bit ax);
        int n;
        if (ax) aq.push_back({wr, a, l});
        dq.push_back({er, ee});
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_len = l;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!hs_cmd && n < 50);
        cmd_valid = 0;
        if (!hs_cmd) check("cmd_timeout", 0, 1);
    endtask

    task automatic send_beat(input bit last);
        int n;
        wr_valid = 1;
        wr_data  = $urandom;
        wq.push_back({wr_data, last});
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!hs_w && n < 100);
        if (!hs_w) check("w_timeout", 0, 1);
    endtask

    task automatic send_wr(input int l);
        for (int i = 0; i <= l; i++) send_beat(i == l);
        wr_valid = 0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!hs_done && n < 3000);
        if (!hs_done) check("done_timeout", 0, 1);
    endtask

    task automatic cmd2(input logic [31:0] a, input bit ok);
        bit aw_seen, hs;
        int n;
        aw_seen = 0; hs = 0;
        cmd_valid2 = 1; cmd_addr2 = a;
        for (n = 0; n < 30; n++) begin
            @(negedge clk);
            if (cmd_valid2 && cmd_ready2) hs = 1;
            if (awvalid2 && !aw_seen) begin
                aw_seen = 1;
                check("aw_size_128", awsize2, 3'd4);
                check("aw_addr_128", awaddr2, a);
            end
            if (wvalid2) begin
                check("w_last_128", {wlast2, wstrb2}, {1'b1, 16'hFFFF});
                check("w_data_128", wdata2[127:64], 64'h0123_4567_89AB_CDEF);
            end
            if (done_valid2) begin
                check("done_128", {done_resp2, done_err2}, ok ? 3'b000 : 3'b101);
                break;
            end
            @(posedge clk); #1;
            if (hs) cmd_valid2 = 0;
        end
        check("aw_seen_128", aw_seen, ok);
        if (n == 30) check("done_timeout_128", 0, 1);
        @(posedge clk); #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
        wr_valid = 0; wr_data = 0; rd_ready = 1;
        awready = 1; wready = 1; arready = 1;
        bvalid = 0; bresp = 0; rvalid = 0; rdata = 0; rresp = 0; rlast = 0;
        cmd_valid2 = 0; cmd_addr2 = 0; wr_valid2 = 1;
        wr_data2 = {2{64'h0123_4567_89AB_CDEF}};
        repeat (3) @(posedge clk);
        #1;
        check("rst_outs", {cmd_ready, awvalid, wvalid, wr_ready, bready, arvalid, rready,
                           rd_valid, rd_last, done_valid, done_resp, done_err, awaddr}, 0);
        rst = 0;
        @(posedge clk); #1;
        check("idle_cmd_ready", cmd_ready, 1);

        do_cmd(1, 32'h1000, 8'd3, 2'b00, 0, 1);
        send_wr(3);
        wait_done();

        cfg_rd_toggle = 1;
        do_cmd(0, 32'h2000, 8'd7, 2'b00, 0, 1);
        wait_done();
        cfg_rd_toggle = 0;

        do_cmd(0, 32'h0FF0, 8'd7, 2'b10, 1, 0);
        wait_done();
        do_cmd(0, 32'h1002, 8'd0, 2'b10, 1, 0);
        wait_done();
        wr_valid = 1;
        do_cmd(1, 32'h1FFC, 8'd1, 2'b10, 1, 0);
        wait_done();
        wr_valid = 0;

        do_cmd(0, 32'h0FC0, 8'd15, 2'b00, 0, 1);
        wait_done();

        cfg_bad_last = 1;
        do_cmd(0, 32'h3000, 8'd3, 2'b00, 1, 1);
        wait_done();
        cfg_bad_last = -1;

        cfg_rresp1 = 2'b10; cfg_rresp2 = 2'b11;
        do_cmd(0, 32'h4000, 8'd3, 2'b10, 0, 1);
        wait_done();
        cfg_rresp1 = 2'b00; cfg_rresp2 = 2'b00;

        cfg_bresp = 2'b11;
        do_cmd(1, 32'h5000, 8'd0, 2'b11, 0, 1);
        send_wr(0);
        wait_done();
        cfg_bresp = 2'b00;

        cfg_w_toggle = 1;
        do_cmd(1, 32'h5100, 8'd4, 2'b00, 0, 1);
        send_wr(4);
        wait_done();
        cfg_w_toggle = 0;

        do_cmd(0, 32'h6000, 8'd255, 2'b00, 0, 1);
        wait_done();

        do_cmd(1, 32'h7000, 8'd5, 2'b00, 0, 1);
        send_beat(0);
        send_beat(0);
        wr_data = $urandom;
        rst = 1;
        #1;
        check("rst_mid_outs", {cmd_ready, awvalid, wvalid, wr_ready, bready, arvalid, rready,
                               rd_valid, done_valid}, 0);
        aq.delete(); wq.delete(); rq.delete(); dq.delete();
        wr_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        @(posedge clk); #1;
        do_cmd(1, 32'h7000, 8'd1, 2'b00, 0, 1);
        send_wr(1);
        wait_done();

        repeat (3) @(posedge clk);
        #1;
        check("aq_empty", aq.size(), 0);
        check("wq_empty", wq.size(), 0);
        check("rq_empty", rq.size(), 0);
        check("dq_empty", dq.size(), 0);

        cmd2(32'h0000_0100, 1);
        cmd2(32'h0000_0108, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
